instr_fetch: RTL and testbench

Instruction fetch front end: the producer side of the 32-bit `instr` word consumed by the control unit and decode logic. Keeps the fetch PC and issues in-order read requests to instruction memory. Buffers returned words in a small FIFO and presents them, with their PC, to decode over a valid/ready handshake. Resolved jumps and taken branches (JAL, JALR, Branch) arrive as a redirect, which flushes buffered and in-flight instructions.

---
 rtl/fetch_pkg.sv | 19 +
 rtl/instr_fifo.sv | 77 +++++++
 rtl/instr_fetch.sv | 129 ++++++++++++
 tb/tb_instr_fetch.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
//   FETCH_DATA_W / FETCH_ADDR_W : widths of one buffered fetch entry
//   RESET_PC_DEFAULT            : default first fetch address after reset
//   INSTR_BYTES                 : byte stride between sequential instructions
//   fetch_entry_t               : {pc, instr} payload held in the fetch FIFO
package fetch_pkg;

    localparam int unsigned FETCH_DATA_W = 32;
    localparam int unsigned FETCH_ADDR_W = 32;
    localparam int unsigned INSTR_BYTES  = 4;

    localparam logic [FETCH_ADDR_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic [FETCH_ADDR_W-1:0] pc;
        logic [FETCH_DATA_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/instr_fifo.sv
// Synchronous FIFO of fetch entries with flush.
//   clk, rst     : clock, synchronous active-high reset
//   push_i       : write push_data_i at the tail (ignored when full)
//   pop_i        : drop the head (ignored when empty)
//   flush_i      : empty the FIFO; wins over push and pop
//   head_o       : current head entry (all-zero after reset)
//   full_o, empty_o, count_o : occupancy status from registered state
module instr_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  fetch_entry_t     push_data_i,
    input  logic             pop_i,
    input  logic             flush_i,
    output fetch_entry_t     head_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    fetch_entry_t     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Pointer/count update; DEPTH is a power of two so pointers wrap naturally.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // Storage is cleared on reset so the head reads as zero until the first push.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (do_push && !flush_i) begin
                mem_q[wr_ptr_q] <= push_data_i;
            end
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch front end: PC generation, credit-limited in-order memory
// requests, response buffering and redirect flush.
//   clk, rst                         : clock, synchronous active-high reset
//   imem_req_valid/addr/ready        : read request channel to instruction memory
//   imem_rsp_valid/data              : in-order read responses (latency >= 1)
//   instr_valid/instr/instr_pc/ready : head of the fetch buffer towards decode
//   redirect_valid/redirect_pc       : resolved jump / taken branch target
module instr_fetch
    import fetch_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH = FETCH_DATA_W,
    parameter int unsigned           ADDR_WIDTH = FETCH_ADDR_W,
    parameter int unsigned           DEPTH      = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = RESET_PC_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  imem_req_valid,
    output logic [ADDR_WIDTH-1:0] imem_req_addr,
    input  logic                  imem_req_ready,
    input  logic                  imem_rsp_valid,
    input  logic [DATA_WIDTH-1:0] imem_rsp_data,
    output logic                  instr_valid,
    output logic [DATA_WIDTH-1:0] instr,
    output logic [ADDR_WIDTH-1:0] instr_pc,
    input  logic                  instr_ready,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned SUM_W = CNT_W + 1;

    logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_WIDTH-1:0] rsp_pc_q, rsp_pc_d;
    logic [ADDR_WIDTH-1:0] redirect_target;
    logic [CNT_W-1:0]      outstanding_q, outstanding_d;
    logic [CNT_W-1:0]      kill_q, kill_d;
    logic [CNT_W-1:0]      fifo_count;
    logic                  credit_ok, req_fire, rsp_keep, fifo_pop;
    logic                  fifo_full, fifo_empty;
    fetch_entry_t          push_entry, head_entry;

    assign redirect_target = redirect_pc & ~ADDR_WIDTH'(INSTR_BYTES - 1);

    // Credit covers buffered plus in-flight words, from registered counts only.
    assign credit_ok      = (SUM_W'(outstanding_q) + SUM_W'(fifo_count)) < SUM_W'(DEPTH);
    assign imem_req_valid = !rst && !redirect_valid && credit_ok;
    assign imem_req_addr  = fetch_pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign rsp_keep = imem_rsp_valid && !redirect_valid && (kill_q == '0);
    assign fifo_pop = instr_valid && instr_ready;

    // rsp_pc_q is the PC of the oldest surviving request: requests after a
    // redirect are sequential from the target and killed words never advance it.
    always_comb begin
        push_entry       = '0;
        push_entry.pc    = FETCH_ADDR_W'(rsp_pc_q);
        push_entry.instr = FETCH_DATA_W'(imem_rsp_data);
    end

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        rsp_pc_d      = rsp_pc_q;
        kill_d        = kill_q;
        outstanding_d = outstanding_q + CNT_W'(req_fire) - CNT_W'(imem_rsp_valid);
        if (redirect_valid) begin
            fetch_pc_d = redirect_target;
            rsp_pc_d   = redirect_target;
            // Every response still owed is stale; outstanding already includes
            // words previously marked for kill, so it is not added on top.
            kill_d     = outstanding_q - CNT_W'(imem_rsp_valid);
        end else begin
            if (req_fire) begin
                fetch_pc_d = fetch_pc_q + ADDR_WIDTH'(INSTR_BYTES);
            end
            if (imem_rsp_valid && (kill_q != '0)) begin
                kill_d = kill_q - CNT_W'(1);
            end
            if (rsp_keep) begin
                rsp_pc_d = rsp_pc_q + ADDR_WIDTH'(INSTR_BYTES);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q    <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
            outstanding_q <= '0;
            kill_q        <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            rsp_pc_q      <= rsp_pc_d;
            outstanding_q <= outstanding_d;
            kill_q        <= kill_d;
        end
    end

    instr_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (rsp_keep),
        .push_data_i (push_entry),
        .pop_i       (fifo_pop),
        .flush_i     (redirect_valid),
        .head_o      (head_entry),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

    assign instr_valid = !fifo_empty;
    assign instr       = DATA_WIDTH'(head_entry.instr);
    assign instr_pc    = ADDR_WIDTH'(head_entry.pc);

    // Memory must not answer more requests than it accepted.
    a_rsp_matched : assert property (@(posedge clk) disable iff (rst)
        imem_rsp_valid |-> (outstanding_q != '0))
        else $error("instr_fetch: imem response without an outstanding request");

    a_no_overflow : assert property (@(posedge clk) disable iff (rst)
        rsp_keep |-> !fifo_full)
        else $error("instr_fetch: push into a full fetch buffer");

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;

    localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        req_valid;
    logic [31:0] req_addr;
    logic        req_ready = 1'b0;
    logic        rsp_valid = 1'b0;
    logic [31:0] rsp_data = 32'h0;
    logic        instr_valid;
    logic [31:0] instr, instr_pc;
    logic        instr_ready = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;

    logic        w_req_valid, w_instr_valid;
    logic [31:0] w_req_addr, w_instr, w_instr_pc;

    instr_fetch #(.DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(req_valid), .imem_req_addr(req_addr), .imem_req_ready(req_ready),
        .imem_rsp_valid(rsp_valid), .imem_rsp_data(rsp_data),
        .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc), .instr_ready(instr_ready),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    // Second instance only observes address wrap from a high reset PC.
    instr_fetch #(.DEPTH(4), .RESET_PC(WRAP_PC)) dut_wrap (
        .clk(clk), .rst(rst),
        .imem_req_valid(w_req_valid), .imem_req_addr(w_req_addr), .imem_req_ready(1'b1),
        .imem_rsp_valid(1'b0), .imem_rsp_data(32'h0),
        .instr_valid(w_instr_valid), .instr(w_instr), .instr_pc(w_instr_pc), .instr_ready(1'b0),
        .redirect_valid(1'b0), .redirect_pc(32'h0)
    );

    typedef struct { logic [31:0] pc; logic [31:0] ins; } exp_t;
    typedef struct { int due; logic [31:0] addr; } pend_t;

    exp_t        exp_q[$];
    pend_t       pend_q[$];
    int          tests = 0, fails = 0;
    int          cyc = 0, lat = 1, last_due = 0, pops = 0, accepts = 0;
    logic [31:0] gen_pc = 32'h0;
    logic [31:0] exp_req_pc = 32'h0;

    function automatic logic [31:0] word_at(input logic [31:0] pc);
        return (pc * 32'h9E37_79B9) ^ 32'h1357_9BDF;
    endfunction

    function automatic logic [31:0] align(input logic [31:0] pc);
        return {pc[31:2], 2'b00};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Architectural instruction stream: sequential from the last fetch target.
    task automatic refill();
        while (exp_q.size() < 8) begin
            exp_q.push_back('{pc: gen_pc, ins: word_at(gen_pc)});
            gen_pc = gen_pc + 32'd4;
        end
    endtask

    // Apply one cycle of stimulus (called at a falling edge) and record memory traffic.
    task automatic drive(input logic rq, input logic ir, input logic rv, input logic [31:0] rp);
        int d;
        req_ready      = rq;
        instr_ready    = ir;
        redirect_valid = rv;
        redirect_pc    = rp;
        if (pend_q.size() != 0 && pend_q[0].due <= cyc) begin
            rsp_valid = 1'b1;
            rsp_data  = word_at(pend_q[0].addr);
            void'(pend_q.pop_front());
        end else begin
            rsp_valid = 1'b0;
            rsp_data  = 32'h0;
        end
        #2;
        if (req_valid && req_ready) begin
            d = cyc + lat;
            if (d <= last_due) d = last_due + 1;
            last_due = d;
            pend_q.push_back('{due: d, addr: req_addr});
            accepts++;
        end
        if (rv) begin
            exp_q.delete();
            gen_pc = align(rp);
        end
        refill();
    endtask

    task automatic step(input logic rq, input logic ir, input logic rv, input logic [31:0] rp);
        @(negedge clk);
        cyc++;
        drive(rq, ir, rv, rp);
    endtask

    // Hold reset, check reset values, then release; caller drives the first cycle.
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; req_ready = 1'b0; instr_ready = 1'b0;
        redirect_valid = 1'b0; rsp_valid = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_req_valid", 32'(req_valid), 32'h0);
        chk("rst_instr_valid", 32'(instr_valid), 32'h0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_instr_pc", instr_pc, 32'h0);
        chk("rst_wrap_valid", 32'(w_instr_valid), 32'h0);
        chk("rst_wrap_pc", w_instr_pc ^ w_instr, 32'h0);
        @(negedge clk);
        pend_q.delete(); last_due = 0;
        exp_q.delete(); gen_pc = 32'h0; refill();
        rst = 1'b0;
        cyc++;
    endtask

    // Monitor: scoreboard pops, request addresses, head stability under back-pressure.
    logic        hold_q = 1'b0;
    logic [31:0] hold_pc, hold_ins;
    exp_t        e;
    initial forever begin
        @(negedge clk);
        #1;
        if (rst) begin
            exp_req_pc = 32'h0;
            hold_q     = 1'b0;
        end else begin
            if (hold_q) begin
                chk("hold_valid", 32'(instr_valid), 32'h1);
                chk("hold_pc", instr_pc, hold_pc);
                chk("hold_instr", instr, hold_ins);
            end
            hold_q   = instr_valid && !instr_ready && !redirect_valid;
            hold_pc  = instr_pc;
            hold_ins = instr;
            if (instr_valid && instr_ready) begin
                pops++;
                if (exp_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL sb_empty: got pc %h, expected no delivery", instr_pc);
                end else begin
                    e = exp_q.pop_front();
                    chk("instr_pc", instr_pc, e.pc);
                    chk("instr", instr, e.ins);
                end
            end
            if (redirect_valid) chk("req_in_redirect", 32'(req_valid), 32'h0);
            if (req_valid && req_ready) begin
                chk("req_addr", req_addr, exp_req_pc);
                exp_req_pc = exp_req_pc + 32'd4;
            end
            if (redirect_valid) exp_req_pc = align(redirect_pc);
        end
    end

    initial begin
        logic        rq, ir, rv;
        logic [31:0] rp;
        refill();

        // Reset and first fetch, L=1
        do_reset(); lat = 1;
        drive(1, 1, 0, 0);
        chk("t1_req_valid", 32'(req_valid), 32'h1);
        chk("t1_addr0", req_addr, 32'h0);
        chk("t1_wrap0", w_req_addr, WRAP_PC);
        chk("t1_nvalid0", 32'(instr_valid), 32'h0);
        step(1, 1, 0, 0);
        chk("t1_addr1", req_addr, 32'h4);
        chk("t1_wrap1", w_req_addr, 32'hFFFF_FFFC);
        chk("t1_nvalid1", 32'(instr_valid), 32'h0);
        step(1, 1, 0, 0);
        chk("t1_addr2", req_addr, 32'h8);
        chk("t1_wrap2", w_req_addr, 32'h0);
        chk("t1_valid2", 32'(instr_valid), 32'h1);
        chk("t1_pc2", instr_pc, 32'h0);
        repeat (10) step(1, 1, 0, 0);

        // Back-pressure: 10 cycles with decode stalled
        do_reset(); lat = 1; accepts = 0;
        drive(1, 0, 0, 0);
        for (int i = 1; i < 10; i++) begin
            step(1, 0, 0, 0);
            if (i >= 2) chk("t2_head_pc", instr_pc, 32'h0);
        end
        chk("t2_req_count", 32'(accepts), 32'd4);
        chk("t2_stalled", 32'(req_valid), 32'h0);
        chk("t2_head_valid", 32'(instr_valid), 32'h1);
        chk("t2_head_instr", instr, word_at(32'h0));
        accepts = 0;
        repeat (8) step(1, 1, 0, 0);
        chk("t2_resume", 32'(accepts >= 4), 32'h1);

        // Redirect with three requests in flight, L=4
        do_reset(); lat = 4;
        drive(1, 1, 0, 0);
        step(1, 1, 0, 0);
        step(1, 1, 0, 0);
        step(1, 1, 1, 32'h100);
        step(1, 1, 0, 0);
        chk("t3_empty", 32'(instr_valid), 32'h0);
        chk("t3_target_req", req_addr, 32'h100);
        chk("t3_target_valid", 32'(req_valid), 32'h1);
        for (int i = 0; i < 4; i++) begin
            step(1, 1, 0, 0);
            chk("t3_no_stale", 32'(instr_valid), 32'h0);
        end
        step(1, 1, 0, 0);
        chk("t3_first_valid", 32'(instr_valid), 32'h1);
        chk("t3_first_pc", instr_pc, 32'h100);
        repeat (6) step(1, 1, 0, 0);

        // Redirect coinciding with a response and a pop, misaligned target, L=2
        do_reset(); lat = 2;
        drive(1, 1, 0, 0);
        repeat (7) step(1, 1, 0, 0);
        step(1, 1, 1, 32'h203);
        chk("t4_rsp_same_cycle", 32'(rsp_valid), 32'h1);
        chk("t4_pop_same_cycle", 32'(instr_valid), 32'h1);
        step(1, 1, 0, 0);
        chk("t4_flushed", 32'(instr_valid), 32'h0);
        chk("t4_aligned_req", req_addr, 32'h200);
        for (int i = 0; i < 2; i++) begin
            step(1, 1, 0, 0);
            chk("t4_no_stale", 32'(instr_valid), 32'h0);
        end
        step(1, 1, 0, 0);
        chk("t4_first_valid", 32'(instr_valid), 32'h1);
        chk("t4_first_pc", instr_pc, 32'h200);
        repeat (6) step(1, 1, 0, 0);

        // Memory not accepting: address and credit held
        do_reset(); lat = 1;
        drive(1, 1, 0, 0);
        step(1, 1, 0, 0);
        for (int i = 0; i < 5; i++) begin
            step(0, 1, 0, 0);
            chk("t6_hold_addr", req_addr, 32'h8);
            chk("t6_hold_valid", 32'(req_valid), 32'h1);
        end
        step(1, 1, 0, 0);
        chk("t6_accept_addr", req_addr, 32'h8);
        step(1, 1, 0, 0);
        chk("t6_next_addr", req_addr, 32'hC);
        repeat (6) step(1, 1, 0, 0);

        // Randomized traffic against the architectural stream
        do_reset(); lat = 1; pops = 0;
        drive(1, 1, 0, 0);
        for (int i = 0; i < 4000; i++) begin
            lat = $urandom_range(1, 3);
            rq  = ($urandom_range(0, 3) != 0);
            ir  = ($urandom_range(0, 9) < 7);
            rv  = ($urandom_range(0, 39) == 0);
            rp  = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                             : 32'($urandom);
            step(rq, ir, rv, rp);
        end
        chk("rand_progress", 32'(pops >= 800), 32'h1);

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
